mc_state_fsm: RTL

//  State register and next-state logic for the multicycle MIPS controller.

---
 rtl/mc_state_fsm.sv | 98 +++++++++
 1 files changed

// File: rtl/mc_state_fsm.sv
// State register and next-state logic for the multicycle MIPS controller.
// Also tracks a sticky illegal-opcode flag and a retired-instruction counter.
module mc_state_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [5:0]       op,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  // Encoding is shared with maindec and must not change.
  localparam logic [3:0] S_FETCH    = 4'h0;
  localparam logic [3:0] S_DECODE   = 4'h1;
  localparam logic [3:0] S_MEMADR   = 4'h2;
  localparam logic [3:0] S_MEMRD    = 4'h3;
  localparam logic [3:0] S_MEMWB    = 4'h4;
  localparam logic [3:0] S_MEMWR    = 4'h5;
  localparam logic [3:0] S_EXECUTE  = 4'h6;
  localparam logic [3:0] S_ALUWB    = 4'h7;
  localparam logic [3:0] S_BEQ      = 4'h8;
  localparam logic [3:0] S_ADDIEXEC = 4'h9;
  localparam logic [3:0] S_ADDIWB   = 4'hA;
  localparam logic [3:0] S_JEX      = 4'hB;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [3:0]       state_q, state_d;
  logic             illegal_q;
  logic             illegal_set;
  logic             last_state;
  logic [CNT_W-1:0] count_q;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = S_FETCH;
    illegal_set = 1'b0;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JEX;
          default:      illegal_set = 1'b1;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
      end
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      // Final states and the unreachable C..F encodings all return to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (state_q)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_ADDIWB, S_JEX: last_state = 1'b1;
      default:                                           last_state = 1'b0;
    endcase
  end

  // state_q is FETCH while in reset, so instr_done is low there without extra gating.
  assign instr_done = en & last_state;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      if (illegal_set) illegal_q <= 1'b1;
      if (last_state)  count_q   <= count_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule
